// File: rtl/adder_op_sched.sv
// Operand scheduler: pairs queued A/B operands in order and issues them to the adder with credit flow control.
// Sums return into a first-word-fall-through result FIFO; an IDLE/RUN/FLUSH FSM sequences the datapath.
module adder_op_sched #(
  parameter int DATA_W    = 16,
  parameter int Q_DEPTH   = 4,
  parameter int RES_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              flush,
  output logic              busy,
  output logic              err,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_valid,
  output logic              b_ready,
  output logic [DATA_W-1:0] add_a,
  output logic [DATA_W-1:0] add_b,
  output logic              add_valid,
  input  logic [DATA_W:0]   add_sum,
  input  logic              add_sum_valid,
  output logic [DATA_W:0]   res_data,
  output logic              res_valid,
  input  logic              res_ready
);

  localparam int QAW = $clog2(Q_DEPTH);
  localparam int RAW = $clog2(RES_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state;

  logic [DATA_W-1:0] a_mem [Q_DEPTH];
  logic [DATA_W-1:0] b_mem [Q_DEPTH];
  logic [DATA_W:0]   r_mem [RES_DEPTH];

  logic [QAW:0] a_wr, a_rd, b_wr, b_rd, a_cnt, b_cnt;
  logic [RAW:0] r_wr, r_rd, r_cnt, inflight;
  logic [RAW+1:0] credits_used;

  logic a_push, b_push, r_push, r_pop, issue, flush_entry, sum_ok;

  assign a_cnt = a_wr - a_rd;
  assign b_cnt = b_wr - b_rd;
  assign r_cnt = r_wr - r_rd;
  assign credits_used = {1'b0, inflight} + {1'b0, r_cnt};

  assign a_ready = (a_cnt != (QAW+1)'(Q_DEPTH)) && (state != FLUSH);
  assign b_ready = (b_cnt != (QAW+1)'(Q_DEPTH)) && (state != FLUSH);
  assign a_push  = a_valid && a_ready;
  assign b_push  = b_valid && b_ready;

  assign issue = (state == RUN) && (a_cnt != '0) && (b_cnt != '0) &&
                 (credits_used < (RAW+2)'(RES_DEPTH));
  assign flush_entry = (state == RUN) && flush;

  // A sum arriving with nothing in flight is an adder protocol error and is dropped.
  assign sum_ok = add_sum_valid && (inflight != '0);
  assign r_push = sum_ok;
  assign r_pop  = res_valid && res_ready;

  assign res_valid = (r_cnt != '0);
  assign res_data  = res_valid ? r_mem[r_rd[RAW-1:0]] : '0;

  assign busy = (state != IDLE) || (a_cnt != '0) || (b_cnt != '0) ||
                (r_cnt != '0) || (inflight != '0);

  always_ff @(posedge clk) begin
    if (a_push) a_mem[a_wr[QAW-1:0]] <= a_data;
    if (b_push) b_mem[b_wr[QAW-1:0]] <= b_data;
    if (r_push) r_mem[r_wr[RAW-1:0]] <= add_sum;
  end

  // Flush entry discards both operand queues; it wins over any push/pop on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_wr <= '0;
      a_rd <= '0;
      b_wr <= '0;
      b_rd <= '0;
    end else if (flush_entry) begin
      a_wr <= '0;
      a_rd <= '0;
      b_wr <= '0;
      b_rd <= '0;
    end else begin
      if (a_push) a_wr <= a_wr + 1'b1;
      if (b_push) b_wr <= b_wr + 1'b1;
      if (issue) begin
        a_rd <= a_rd + 1'b1;
        b_rd <= b_rd + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr     <= '0;
      r_rd     <= '0;
      inflight <= '0;
      err      <= 1'b0;
    end else begin
      if (r_push) r_wr <= r_wr + 1'b1;
      if (r_pop)  r_rd <= r_rd + 1'b1;
      if (issue && !sum_ok)      inflight <= inflight + 1'b1;
      else if (!issue && sum_ok) inflight <= inflight - 1'b1;
      if (add_sum_valid && (inflight == '0)) err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_a     <= '0;
      add_b     <= '0;
      add_valid <= 1'b0;
    end else begin
      add_valid <= issue;
      if (issue) begin
        add_a <= a_mem[a_rd[QAW-1:0]];
        add_b <= b_mem[b_rd[QAW-1:0]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (en) state <= RUN;
        RUN:     if (flush) state <= FLUSH;
                 else if (!en) state <= IDLE;
        FLUSH:   if (inflight == '0) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_op_sched.sv
// Randomized and directed bench for adder_op_sched against a queue-based behavioural model.
// The bench also plays the adder, returning each expected sum one cycle after its issue.
module tb_adder_op_sched;

  localparam int DW = 16;
  localparam int QD = 4;
  localparam int RD = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_FLUSH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en, flush, busy, err;
  logic [DW-1:0] a_data, b_data, add_a, add_b;
  logic          a_valid, a_ready, b_valid, b_ready, add_valid;
  logic [DW:0]   add_sum, res_data;
  logic          add_sum_valid, res_valid, res_ready;

  adder_op_sched #(.DATA_W(DW), .Q_DEPTH(QD), .RES_DEPTH(RD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .busy(busy), .err(err),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .add_a(add_a), .add_b(add_b), .add_valid(add_valid),
    .add_sum(add_sum), .add_sum_valid(add_sum_valid),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  int aq[$], bq[$], rq[$];
  int s_due[$], s_sum[$];
  int m_state, m_inflight;
  bit m_err, m_add_valid;
  int m_add_a, m_add_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic checkOutput();
    chk("add_valid", 32'(add_valid), 32'(m_add_valid));
    chk("add_a", 32'(add_a), 32'(m_add_a));
    chk("add_b", 32'(add_b), 32'(m_add_b));
    chk("a_ready", 32'(a_ready), 32'(aq.size() < QD && m_state != M_FLUSH));
    chk("b_ready", 32'(b_ready), 32'(bq.size() < QD && m_state != M_FLUSH));
    chk("res_valid", 32'(res_valid), 32'(rq.size() > 0));
    chk("res_data", 32'(res_data), (rq.size() > 0) ? 32'(rq[0]) : 32'd0);
    chk("busy", 32'(busy), 32'(m_state != M_IDLE || aq.size() > 0 || bq.size() > 0 ||
                               rq.size() > 0 || m_inflight != 0));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic modelReset();
    aq.delete(); bq.delete(); rq.delete(); s_due.delete(); s_sum.delete();
    m_state = M_IDLE; m_inflight = 0; m_err = 0;
    m_add_valid = 0; m_add_a = 0; m_add_b = 0;
  endtask

  task automatic driveIdle();
    en = 0; flush = 0; a_valid = 0; b_valid = 0; a_data = '0; b_data = '0;
    res_ready = 0; add_sum_valid = 0; add_sum = '0;
  endtask

  // One clock cycle: drive inputs, play the adder, advance the model, then check after the edge.
  task automatic applyStimulus(input bit av, input int ad, input bit bv, input int bd,
                               input bit rr, input bit e, input bit f, input bit spur);
    bit sv, iss, rdy_a, rdy_b;
    int sum, inf0, ea, eb;
    a_valid = av; a_data = ad[DW-1:0];
    b_valid = bv; b_data = bd[DW-1:0];
    res_ready = rr; en = e; flush = f;
    sv = 0; sum = 0;
    if (s_due.size() > 0 && s_due[0] == cyc) begin
      sv = 1; sum = s_sum.pop_front(); void'(s_due.pop_front());
    end else if (spur) begin
      sv = 1; sum = int'($urandom_range(0, 131071));
    end
    add_sum_valid = sv; add_sum = sum[DW:0];

    inf0  = m_inflight;
    rdy_a = aq.size() < QD && m_state != M_FLUSH;
    rdy_b = bq.size() < QD && m_state != M_FLUSH;
    iss   = m_state == M_RUN && aq.size() > 0 && bq.size() > 0 && (inf0 + rq.size()) < RD;
    if (rr && rq.size() > 0) void'(rq.pop_front());
    m_add_valid = iss;
    if (iss) begin
      ea = aq.pop_front(); eb = bq.pop_front();
      m_add_a = ea; m_add_b = eb;
      s_due.push_back(cyc + 1); s_sum.push_back(ea + eb);
    end
    if (av && rdy_a) aq.push_back(ad & 32'hFFFF);
    if (bv && rdy_b) bq.push_back(bd & 32'hFFFF);
    if (m_state == M_RUN && f) begin aq.delete(); bq.delete(); end
    if (sv) begin
      if (inf0 == 0) m_err = 1;
      else begin rq.push_back(sum); m_inflight--; end
    end
    if (iss) m_inflight++;
    case (m_state)
      M_IDLE:  if (e) m_state = M_RUN;
      M_RUN:   if (f) m_state = M_FLUSH; else if (!e) m_state = M_IDLE;
      default: if (inf0 == 0) m_state = M_IDLE;
    endcase

    @(posedge clk);
    #1;
    cyc++;
    checkOutput();
  endtask

  task automatic idleCycles(input int n, input bit rr, input bit e);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, rr, e, 0, 0);
  endtask

  int issues;
  int waited;

  initial begin
    rst_n = 0;
    driveIdle();
    modelReset();
    #2;
    checkOutput();
    #2 rst_n = 1;

    $display("[TB] single pair 5+7");
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(1, 5, 1, 7, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    chk("t1_add_valid", 32'(add_valid), 32'd1);
    chk("t1_add_a", 32'(add_a), 32'd5);
    chk("t1_add_b", 32'(add_b), 32'd7);
    waited = 0;
    while (!res_valid && waited < 8) begin
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
      waited++;
    end
    chk("t1_res_data", 32'(res_data), 32'd12);
    idleCycles(2, 1, 1);

    $display("[TB] A first, then B");
    for (int i = 1; i <= 3; i++) applyStimulus(1, i, 0, 0, 1, 1, 0, 0);
    for (int i = 1; i <= 3; i++) applyStimulus(0, 0, 1, 10 * i, 1, 1, 0, 0);
    idleCycles(6, 1, 1);

    $display("[TB] credit limit with res_ready low");
    issues = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, int'($urandom_range(0, 65535)), 1, int'($urandom_range(0, 65535)), 0, 1, 0, 0);
      if (add_valid) issues++;
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
      if (add_valid) issues++;
    end
    chk("t3_issues_stalled", 32'(issues), 32'd4);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 1, 0, 0);
      if (add_valid) issues++;
    end
    chk("t3_issues_total", 32'(issues), 32'd6);

    $display("[TB] fill A queue");
    for (int i = 0; i < 4; i++) applyStimulus(1, 100 + i, 0, 0, 1, 1, 0, 0);
    chk("t4_a_full", 32'(a_ready), 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 200 + i, 1, 1, 0, 0);
    idleCycles(6, 1, 1);
    chk("t4_a_ready_back", 32'(a_ready), 32'd1);

    $display("[TB] flush with pairs in flight");
    for (int i = 0; i < 3; i++) applyStimulus(1, 40 + i, 1, 50 + i, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 0);
    idleCycles(6, 0, 1);
    chk("t5_busy_results", 32'(busy), 32'd1);
    idleCycles(6, 1, 0);
    chk("t5_busy_idle", 32'(busy), 32'd0);

    $display("[TB] unexpected sum");
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 1);
    chk("t6_err_set", 32'(err), 32'd1);
    idleCycles(3, 1, 0);
    chk("t6_err_sticky", 32'(err), 32'd1);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++)
      applyStimulus(bit'($urandom_range(0, 1)), int'($urandom_range(0, 65535)),
                    bit'($urandom_range(0, 1)), int'($urandom_range(0, 65535)),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 15) != 0,
                    $urandom_range(0, 31) == 0, 0);

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 3; i++) applyStimulus(1, 9 + i, 1, 3 + i, 0, 1, 0, 0);
    rst_n = 0;
    driveIdle();
    modelReset();
    #1;
    checkOutput();
    #1 rst_n = 1;
    idleCycles(3, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
